dsp_mac_sequencer: RTL and testbench

//  Initiator-side driver for the DSP48A1 slice. It turns a command (term count N) and a

---
 rtl/dsp_mac_sequencer.sv | 162 ++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - command/operand sequencer driving a DSP48A1 slice through a sum-of-products
module dsp_mac_sequencer #(
    parameter int MAC_LAT = 3,
    parameter int OPM_DLY = 1,
    parameter int LEN_W   = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [17:0]      op_a,
    input  logic [17:0]      op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_p,
    output logic             res_cout,
    output logic             busy,
    output logic [17:0]      DSP_A,
    output logic [17:0]      DSP_B,
    output logic [7:0]       DSP_OPMODE,
    output logic             DSP_CE,
    output logic             DSP_RST,
    input  logic [47:0]      DSP_P,
    input  logic             DSP_CARRYOUT
);

    // Only OPMODE[3:0] (Z and X muxes) is ever non-zero, so the tag line carries 4 bits.
    localparam logic [3:0] TAG_FIRST = 4'h1;
    localparam logic [3:0] TAG_ACC   = 4'h9;
    localparam logic [3:0] TAG_HOLD  = 4'h8;
    localparam int         DW        = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DRAIN,
        S_CAPT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] rem_cnt;
    logic [DW-1:0]    drain_cnt;
    logic             first_op;
    logic             live;
    logic             accept;
    logic [3:0]       cur_tag;
    logic [3:0]       tag_out;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid && live) state_nxt = S_CLR;
            S_CLR:   state_nxt = (rem_cnt != '0) ? S_RUN : S_CAPT;
            S_RUN:   if (accept && rem_cnt == LEN_W'(1)) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == '0) state_nxt = S_CAPT;
            S_CAPT:  state_nxt = S_DONE;
            S_DONE:  if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        DSP_CE    = 1'b0;
        DSP_RST   = 1'b0;
        cur_tag   = TAG_HOLD;
        case (state)
            S_IDLE: begin
                cmd_ready = live;
                busy      = 1'b0;
                DSP_RST   = 1'b1;
            end
            S_CLR: DSP_RST = 1'b1;
            S_RUN: begin
                op_ready = (rem_cnt != '0);
                DSP_CE   = op_valid && (rem_cnt != '0);
                if (DSP_CE) cur_tag = first_op ? TAG_FIRST : TAG_ACC;
            end
            S_DRAIN: DSP_CE    = 1'b1;
            S_DONE:  res_valid = 1'b1;
            default: busy      = 1'b1;
        endcase
    end

    assign accept = op_valid && op_ready;
    assign DSP_A  = accept ? op_a : 18'h0;
    assign DSP_B  = accept ? op_b : 18'h0;

    // live keeps cmd_ready low while reset is held and for the first edge after release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            live      <= 1'b0;
            rem_cnt   <= '0;
            drain_cnt <= '0;
            first_op  <= 1'b0;
            res_p     <= 48'h0;
            res_cout  <= 1'b0;
        end else begin
            live <= 1'b1;
            if (state == S_IDLE && cmd_valid && live) begin
                rem_cnt <= cmd_len;
            end else if (accept) begin
                rem_cnt <= rem_cnt - LEN_W'(1);
            end
            if (state == S_CLR) begin
                first_op <= 1'b1;
            end else if (accept) begin
                first_op <= 1'b0;
            end
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt - DW'(1);
            end else begin
                drain_cnt <= DW'(MAC_LAT - 1);
            end
            if (state == S_CAPT) begin
                res_p    <= DSP_P;
                res_cout <= DSP_CARRYOUT;
            end
        end
    end

    // Tag line advances with the slice clock enable so opcodes stay aligned with their products.
    generate
        if (OPM_DLY == 0) begin : g_tag_direct
            assign tag_out = cur_tag;
        end else begin : g_tag_line
            logic [3:0] tag_sr [OPM_DLY];
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    for (int i = 0; i < OPM_DLY; i++) tag_sr[i] <= TAG_HOLD;
                end else if (DSP_RST) begin
                    for (int i = 0; i < OPM_DLY; i++) tag_sr[i] <= TAG_HOLD;
                end else if (DSP_CE) begin
                    tag_sr[0] <= cur_tag;
                    for (int i = 1; i < OPM_DLY; i++) tag_sr[i] <= tag_sr[i-1];
                end
            end
            assign tag_out = tag_sr[OPM_DLY-1];
        end
    endgenerate

    // The OPMODE register is being cleared while DSP_RST is high, so drive 0 there.
    assign DSP_OPMODE = DSP_RST ? 8'h00 : {4'b0000, tag_out};

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - randomized self-checking bench with a DSP48A1 slice model
module tb_dsp_mac_sequencer;

    localparam int MAC_LAT = 3;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_len = 16'h0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [17:0] op_a = 18'h0;
    logic [17:0] op_b = 18'h0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [47:0] res_p;
    logic        res_cout;
    logic        busy;
    logic [17:0] DSP_A;
    logic [17:0] DSP_B;
    logic [7:0]  DSP_OPMODE;
    logic        DSP_CE;
    logic        DSP_RST;
    logic [47:0] DSP_P;
    logic        DSP_CARRYOUT;

    int checks   = 0;
    int failures = 0;

    logic [17:0] qa[$];
    logic [17:0] qb[$];

    always #5 CLK = ~CLK;

    dsp_mac_sequencer dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_p       (res_p),
        .res_cout    (res_cout),
        .busy        (busy),
        .DSP_A       (DSP_A),
        .DSP_B       (DSP_B),
        .DSP_OPMODE  (DSP_OPMODE),
        .DSP_CE      (DSP_CE),
        .DSP_RST     (DSP_RST),
        .DSP_P       (DSP_P),
        .DSP_CARRYOUT(DSP_CARRYOUT)
    );

    // Slice model: A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, common CE and sync RST.
    logic [17:0] sl_a1, sl_b1;
    logic [35:0] sl_m;
    logic [47:0] sl_p, sl_x, sl_z;
    logic [3:0]  sl_opm;
    logic        sl_co;
    logic [48:0] sl_sum;

    always_comb begin
        case (sl_opm[1:0])
            2'b01:   sl_x = {12'h0, sl_m};
            2'b10:   sl_x = sl_p;
            default: sl_x = 48'h0;
        endcase
        sl_z   = (sl_opm[3:2] == 2'b10) ? sl_p : 48'h0;
        sl_sum = {1'b0, sl_z} + {1'b0, sl_x};
    end

    always @(posedge CLK) begin
        if (DSP_RST) begin
            sl_a1 <= 18'h0; sl_b1 <= 18'h0; sl_m <= 36'h0;
            sl_p <= 48'h0; sl_co <= 1'b0; sl_opm <= 4'h0;
        end else if (DSP_CE) begin
            sl_a1  <= DSP_A;
            sl_b1  <= DSP_B;
            sl_m   <= 36'(sl_a1) * 36'(sl_b1);
            sl_opm <= DSP_OPMODE[3:0];
            sl_p   <= sl_sum[47:0];
            sl_co  <= sl_sum[48];
        end
    end

    assign DSP_P        = sl_p;
    assign DSP_CARRYOUT = sl_co;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issues one command with the operands in qa/qb, then holds res_ready low for hold_cycles.
    task automatic run_cmd(input int n, input int gap_min, input int gap_max,
                           input int hold_cycles, input string tag);
        logic [47:0] exp_p;
        int  k, cyc, gap, ce_cnt;
        bit  acc, bubbles;
        exp_p = 48'h0;
        k = 0; cyc = 0; gap = 0; ce_cnt = 0; bubbles = 1'b0;
        for (int i = 0; i < n; i++) exp_p += 48'(qa[i]) * 48'(qb[i]);

        check({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_len   = 16'(n);
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        while (!res_valid && cyc < 1000) begin
            if (k < n && gap == 0) begin
                op_valid = 1'b1; op_a = qa[k]; op_b = qb[k];
            end else begin
                op_valid = 1'b0; op_a = 18'h0; op_b = 18'h0;
            end
            @(negedge CLK);
            acc = op_valid && op_ready;
            if (DSP_CE) ce_cnt++;
            if (op_ready && !op_valid) begin
                bubbles = 1'b1;
                check({tag, "_bubble_ce"}, DSP_CE, 0);
            end
            if (acc) check({tag, "_dsp_ab"}, {DSP_A, DSP_B}, {qa[k], qb[k]});
            check({tag, "_opm_hi"}, DSP_OPMODE[7:4], 0);
            @(posedge CLK); #1;
            cyc++;
            if (acc) begin
                k++;
                gap = (gap_max == 0) ? 0 : $urandom_range(gap_max, gap_min);
            end else if (!op_valid && gap > 0) begin
                gap--;
            end
        end
        op_valid = 1'b0;
        check({tag, "_no_timeout"}, cyc < 1000, 1);
        check({tag, "_accepted"}, k, n);
        if (!bubbles) check({tag, "_latency"}, cyc, (n == 0) ? 2 : n + MAC_LAT + 2);
        check({tag, "_ce_cycles"}, ce_cnt, (n == 0) ? 0 : n + MAC_LAT);
        check({tag, "_res_p"}, res_p, exp_p);
        check({tag, "_res_cout"}, res_cout, 0);
        check({tag, "_busy"}, busy, 1);
        for (int i = 0; i < hold_cycles; i++) begin
            res_ready = 1'b0;
            @(posedge CLK); #1;
            check({tag, "_hold_valid"}, res_valid, 1);
            check({tag, "_hold_p"}, res_p, exp_p);
            check({tag, "_hold_cmd_ready"}, cmd_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge CLK); #1;
        res_ready = 1'b0;
        check({tag, "_released"}, res_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_dsp_rst", DSP_RST, 1);
        check("rst_outputs", {cmd_ready, op_ready, res_valid, busy, DSP_CE, res_cout}, 0);
        check("rst_opmode", DSP_OPMODE, 0);
        check("rst_res_p", res_p, 0);
        check("rst_dsp_ab", {DSP_A, DSP_B}, 0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        qa = {18'd2, 18'd4, 18'd1}; qb = {18'd3, 18'd5, 18'd7};
        run_cmd(3, 0, 0, 0, "t1");
        check("t1_sum33", res_p, 48'd33);
        run_cmd(3, 2, 2, 0, "t2");
        qa = {}; qb = {};
        run_cmd(0, 0, 0, 0, "t3");
        qa = {18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF};
        qb = {18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF};
        run_cmd(4, 0, 0, 5, "t4");
        qa = {18'd3, 18'd3}; qb = {18'd3, 18'd3};
        run_cmd(2, 0, 0, 0, "t5a");
        qa = {18'd5}; qb = {18'd5};
        run_cmd(1, 0, 0, 0, "t5b");
        check("t5b_sum25", res_p, 48'd25);

        qa = {18'd1, 18'd2, 18'd3, 18'd4, 18'd5}; qb = {18'd1, 18'd2, 18'd3, 18'd4, 18'd5};
        cmd_valid = 1'b1; cmd_len = 16'd5;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = 18'd9; op_b = 18'd9;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("t6_dsp_rst", DSP_RST, 1);
        check("t6_op_ready", op_ready, 0);
        check("t6_busy", busy, 0);
        check("t6_ce", DSP_CE, 0);
        check("t6_res", {res_valid, res_p}, 0);
        op_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        qa = {18'd6}; qb = {18'd7};
        run_cmd(1, 0, 0, 0, "t6");
        check("t6_sum42", res_p, 48'd42);

        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(8, 0);
            qa = {}; qb = {};
            for (int i = 0; i < n; i++) begin
                qa.push_back(18'($urandom));
                qb.push_back(18'($urandom));
            end
            run_cmd(n, 0, (t % 2 == 0) ? 0 : 3, $urandom_range(3, 0), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
